// File: rtl/ripple_count_scheduler.sv
// ripple_count_scheduler
//   Shares one CNT_W-bit interval down-counter among N_REQ requesters.
//   A round-robin arbiter grants the counter to one requester at a time.
//   The owner's load value is captured at grant time and counted down on
//   tick_en-qualified cycles. done[owner] pulses for one cycle at expiry.
//
// Ports
//   clk      rising-edge clock
//   rstn     asynchronous active-low reset
//   req      level request per requester, held until done or abort
//   req_cnt  packed load values, slice i = [i*CNT_W +: CNT_W]
//   tick_en  counter decrements only in cycles where this is 1
//   gnt      one-hot registered owner of the counter
//   done     one-cycle pulse to the owner at count expiry
//   owner    index of the current or last owner
//   busy     1 while a grant is active (RUN or DONE)
//   cnt_q    current counter value

// Per-requester lane: holds this requester's grant bit and decodes its
// done pulse. The grant bit is set on the load edge when this lane wins and
// cleared whenever the scheduler returns to IDLE.
module rcs_lane #(
  parameter int IDX_W = 2,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             clr,
  input  logic [IDX_W-1:0] sel,
  input  logic             in_done,
  output logic             gnt,
  output logic             done
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     gnt <= 1'b0;
    else if (load) gnt <= (sel == IDX_W'(IDX));
    else if (clr)  gnt <= 1'b0;
  end

  // Moore decode: done follows the registered grant while in DONE.
  assign done = gnt & in_done;

endmodule

module ripple_count_scheduler #(
  parameter  int N_REQ = 4,
  parameter  int CNT_W = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] req_cnt,
  input  logic                   tick_en,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [IDX_W-1:0]       owner,
  output logic                   busy,
  output logic [CNT_W-1:0]       cnt_q
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Next-state bundle for the shared counter control.
  typedef struct packed {
    state_t           st;
    logic [IDX_W-1:0] own;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
  } ctl_t;

  state_t           state_q;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] ptr_q;
  ctl_t             nxt;

  logic                        load;
  logic                        clr;
  logic                        win_vld;
  logic [IDX_W-1:0]            win;
  logic [N_REQ-1:0][CNT_W-1:0] cnt_a;

  assign cnt_a = req_cnt;

  // Round-robin search: first set request strictly after the pointer,
  // wrapping once around. ptr_q is the last owner, so it gets lowest
  // priority on the next arbitration.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win     = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    nxt.st  = state_q;
    nxt.own = owner_q;
    nxt.ptr = ptr_q;
    nxt.cnt = cnt_q;
    load    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // req_cnt is only ever sampled here, on the IDLE->RUN edge.
        if (win_vld) begin
          nxt.st  = S_RUN;
          nxt.own = win;
          nxt.cnt = cnt_a[win];
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (!req[owner_q]) begin
          // Owner withdrew: abort silently, counter value is left visible.
          nxt.st  = S_IDLE;
          nxt.ptr = owner_q;
          clr     = 1'b1;
        end else if (cnt_q == '0) begin
          // Expiry check comes before decrement, so the counter never wraps.
          nxt.st = S_DONE;
        end else if (tick_en) begin
          nxt.cnt = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // req is ignored here; the done pulse always completes.
        nxt.st  = S_IDLE;
        nxt.ptr = owner_q;
        clr     = 1'b1;
      end
      default: begin
        nxt.st = S_IDLE;
        clr    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= nxt.st;
      owner_q <= nxt.own;
      ptr_q   <= nxt.ptr;
      cnt_q   <= nxt.cnt;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    rcs_lane #(.IDX_W(IDX_W), .IDX(i)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load),
      .clr     (clr),
      .sel     (win),
      .in_done (state_q == S_DONE),
      .gnt     (gnt[i]),
      .done    (done[i])
    );
  end

  assign busy  = (state_q != S_IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_ripple_count_scheduler.sv
// Testbench for ripple_count_scheduler: directed latency/ordering scenarios
// followed by randomized traffic, all checked against a request-level
// reference model stepped once per clock.
module tb_ripple_count_scheduler;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_cnt;
  logic           tick_en;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [IW-1:0]  owner;
  logic           busy;
  logic [W-1:0]   cnt_q;

  ripple_count_scheduler #(.N_REQ(N), .CNT_W(W)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .req_cnt (req_cnt),
    .tick_en (tick_en),
    .gnt     (gnt),
    .done    (done),
    .owner   (owner),
    .busy    (busy),
    .cnt_q   (cnt_q)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
  endtask

  // Reference model: who holds the counter, how many ticks remain, and
  // whether the holder is in its expiry cycle. m_last is the last holder,
  // which gets lowest priority at the next arbitration.
  int m_phase;   // 0 free, 1 counting, 2 expiring
  int m_owner;
  int m_last;
  int m_left;

  task automatic m_reset();
    m_phase = 0; m_owner = 0; m_last = N - 1; m_left = 0;
  endtask

  task automatic m_step();
    case (m_phase)
      0: if (req != '0) begin
        for (int k = 1; k <= N; k++) begin
          int i;
          i = (m_last + k) % N;
          if (req[i]) begin
            m_owner = i;
            m_left  = int'(req_cnt[i*W +: W]);
            m_phase = 1;
            break;
          end
        end
      end
      1: begin
        if (!req[m_owner]) begin m_phase = 0; m_last = m_owner; end
        else if (m_left == 0) m_phase = 2;
        else if (tick_en) m_left = m_left - 1;
      end
      default: begin m_phase = 0; m_last = m_owner; end
    endcase
  endtask

  task automatic compare();
    logic [N-1:0] eg;
    eg = '0;
    if (m_phase != 0) eg[m_owner] = 1'b1;
    chk("gnt",   32'(gnt),   32'(eg));
    chk("done",  32'(done),  (m_phase == 2) ? 32'(eg) : 32'd0);
    chk("owner", 32'(owner), m_owner);
    chk("busy",  32'(busy),  (m_phase != 0) ? 32'd1 : 32'd0);
    chk("cnt_q", 32'(cnt_q), m_left);
  endtask

  // One clock: inputs are stable across the edge, outputs checked at negedge.
  task automatic cyc();
    @(posedge clk);
    m_step();
    cyc_n++;
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("rst_gnt",   32'(gnt),   0);
    chk("rst_done",  32'(done),  0);
    chk("rst_busy",  32'(busy),  0);
    chk("rst_cnt",   32'(cnt_q), 0);
    chk("rst_owner", 32'(owner), 0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Single requester transaction; reports cycle (from request) of the first
  // grant, of the done pulse, and the number of done pulses seen.
  task automatic run_one(input int who, input int v, input bit alt,
                         output int gl, output int dl, output int nd);
    gl = -1; dl = -1; nd = 0;
    req = '0;
    req[who] = 1'b1;
    req_cnt[who*W +: W] = W'(v);
    tick_en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (alt) tick_en = (k % 2 == 0);
      cyc();
      if (gnt != '0 && gl < 0) gl = k;
      if (done != '0) begin nd++; dl = k; req = '0; end
      if (dl > 0 && k >= dl + 2) break;
    end
    tick_en = 1'b1;
  endtask

  int gl, dl, nd;
  int ord[$];
  int last_done, prev_g;
  bit found;

  initial begin
    rstn = 1'b0; req = '0; req_cnt = '0; tick_en = 1'b1;
    m_reset();
    do_reset();

    // T1: load 5, continuous ticks -> grant at c1, done at c7
    run_one(0, 5, 1'b0, gl, dl, nd);
    chk("t1_gnt_lat", gl, 1);
    chk("t1_done_lat", dl, 7);
    chk("t1_ndone", nd, 1);

    // T2: all four request, each drops after its done
    do_reset();
    req = '1;
    for (int i = 0; i < N; i++) req_cnt[i*W +: W] = W'(2);
    last_done = -1; prev_g = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc();
      if (gnt != '0 && prev_g == 0 && last_done > 0) chk("t2_gap", k - last_done, 2);
      prev_g = int'(gnt != '0);
      if (done != '0) begin
        ord.push_back(int'(owner));
        req[owner] = 1'b0;
        last_done = k;
      end
      if (req == '0 && k >= last_done + 2) break;
    end
    chk("t2_count", ord.size(), N);
    for (int i = 0; i < N; i++) chk("t2_order", (i < ord.size()) ? ord[i] : -1, i);

    // T3: ticks on alternate cycles -> third qualified tick at c6, done c7
    run_one(0, 3, 1'b1, gl, dl, nd);
    chk("t3_done_lat", dl, 7);
    chk("t3_ndone", nd, 1);

    // T5: load boundaries
    run_one(2, 0, 1'b0, gl, dl, nd);
    chk("t5_zero_lat", dl - gl, 1);
    run_one(0, 15, 1'b0, gl, dl, nd);
    chk("t5_max_lat", dl - gl, 16);

    // T4: abort by owner 1 at cnt_q==2, requester 2 pending
    req = 4'b0110;
    req_cnt[1*W +: W] = W'(6);
    req_cnt[2*W +: W] = W'(3);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (gnt == 4'b0010 && cnt_q == W'(2)) begin found = 1'b1; break; end
    end
    chk("t4_reach", 32'(found), 1);
    req[1] = 1'b0;
    cyc();
    chk("t4_gnt",  32'(gnt),   0);
    chk("t4_busy", 32'(busy),  0);
    chk("t4_cnt",  32'(cnt_q), 2);
    chk("t4_done", 32'(done),  0);
    cyc();
    chk("t4_next", 32'(gnt), 32'b0100);
    for (int k = 0; k < 20 && req != '0; k++) begin
      cyc();
      if (done != '0) req = '0;
    end
    cyc(); cyc();

    // T6: async reset mid-RUN, then req1 wins over req3
    req = 4'b0001;
    req_cnt[0 +: W] = W'(10);
    cyc(); cyc(); cyc();
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("t6_gnt",   32'(gnt),   0);
    chk("t6_done",  32'(done),  0);
    chk("t6_busy",  32'(busy),  0);
    chk("t6_cnt",   32'(cnt_q), 0);
    chk("t6_owner", 32'(owner), 0);
    m_reset();
    req = 4'b1010;
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    chk("t6_first", 32'(gnt), 32'b0010);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (m_phase != 0 && i == m_owner) begin
          if (m_phase == 1 && $urandom_range(0, 24) == 0) req[i] = 1'b0;
          else if (m_phase == 2 && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = ~req[i];
        end
        case ($urandom_range(0, 7))
          0:       req_cnt[i*W +: W] = '0;
          1:       req_cnt[i*W +: W] = '1;
          default: req_cnt[i*W +: W] = W'($urandom_range(0, 15));
        endcase
      end
      tick_en = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
